// File: rtl/arb_burst_master_if.sv
// -----------------------------------------------------------------------------
// arb_burst_master_if
// Bundles the command, arbiter and data-bus signals of one burst requester.
//
// Handshake rules (one place, applies to every channel below):
//   - cmd:  a command transfers on a rising clk edge where cmd_valid and
//           cmd_ready are both 1; cmd_len/cmd_base must be stable while
//           cmd_valid is 1.
//   - req/gnt: req is a registered request; the arbiter answers with gnt on a
//           later cycle. gnt is advisory: the requester only uses it while it
//           actually owns a burst.
//   - bus:  bus_valid marks a beat this cycle; bus_data/bus_last are
//           meaningful only while bus_valid is 1. There is no back-pressure.
//
// Signals:
//   cmd_valid, cmd_len, cmd_base  : command from the producer
//   cmd_ready                     : requester can accept a command
//   req / gnt                     : arbiter request / grant
//   bus_valid, bus_data, bus_last : beat output
//   busy, done                    : status (done is a one-cycle pulse)
//
// Modports:
//   master : the requester (drives cmd_ready, req, bus_*, busy, done)
//   slave  : its environment (drives cmd_*, gnt)
// -----------------------------------------------------------------------------
interface arb_burst_master_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_base;
    logic              req;
    logic              gnt;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_len, cmd_base, gnt,
        output cmd_ready, req, bus_valid, bus_data, bus_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_base, gnt,
        input  cmd_ready, req, bus_valid, bus_data, bus_last, busy, done
    );
endinterface

// File: rtl/arb_burst_master.sv
// -----------------------------------------------------------------------------
// arb_burst_master
// Requester-side agent for one port of a two-input request/grant arbiter.
// Accepts a burst command (cmd_len+1 beats starting at data value cmd_base),
// raises req, and emits one beat on every granted cycle until the burst is
// complete. After the burst, req stays low for GAP cycles (GAPW state) so the
// other requester can win before a new command is accepted.
//
// Ports:
//   clk        : clock
//   rst        : asynchronous, active-low reset
//   bus        : arb_burst_master_if.master (cmd, req/gnt, beat bus, status)
//   dbg_state  : current FSM state (0 IDLE, 1 ACTIVE, 2 GAPW)
//
// Parameters:
//   DATA_W : width of cmd_base / bus_data
//   LEN_W  : width of cmd_len (burst length 1..2**LEN_W)
//   GAP    : idle cycles with req low after a burst (0 allowed)
// -----------------------------------------------------------------------------
module arb_burst_master #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int GAP    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    arb_burst_master_if.master    bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAPW   = 2'd2
    } state_t;

    // Gap counter counts 0..GAP-1; keep at least one bit so GAP=0/1 still
    // elaborate cleanly (GAPW is unreachable when GAP=0).
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;     // base + cnt, advanced together with cnt
    logic [GAP_W-1:0]  gap_cnt;
    logic              req_q;
    logic              done_q;
    logic              busy_q;
    logic              cmd_ready_q;

    logic beat;
    logic last_beat;

    // A beat needs both ownership of a burst and a grant; a grant that
    // trails the burst by one cycle lands outside ACTIVE and is ignored.
    assign beat      = (state == ACTIVE) && bus.gnt;
    assign last_beat = beat && (cnt == len_q);

    assign bus.bus_valid = beat;
    assign bus.bus_last  = last_beat;
    assign bus.bus_data  = data_q;
    assign bus.req       = req_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            data_q      <= '0;
            gap_cnt     <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        len_q       <= bus.cmd_len;
                        data_q      <= bus.cmd_base;
                        cnt         <= '0;
                        state       <= ACTIVE;
                        req_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                    end
                end

                ACTIVE: begin
                    // Without a grant everything holds, so a lost grant
                    // resumes on exactly the beat that was pending.
                    if (beat) begin
                        if (last_beat) begin
                            // cnt is not advanced here, so a maximum-length
                            // burst never wraps the counter.
                            req_q  <= 1'b0;
                            done_q <= 1'b1;
                            if (GAP > 0) begin
                                state   <= GAPW;
                                gap_cnt <= '0;
                            end else begin
                                state       <= IDLE;
                                busy_q      <= 1'b0;
                                cmd_ready_q <= 1'b1;
                            end
                        end else begin
                            cnt    <= cnt + 1'b1;
                            data_q <= data_q + 1'b1;
                        end
                    end
                end

                GAPW: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    req_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
